// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requester FSMs and mem_arbiter: request/release in,
// grant/select/enable/busy out.
interface mem_arbiter_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned SEL_W = 3
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             mem_en;
  logic             busy;

  modport master (
    output req, done,
    input  grant, sel, mem_en, busy
  );

  modport slave (
    input  req, done,
    output grant, sel, mem_en, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared memory address path, one turnaround cycle between grants.
// Optional forced release after MAX_HOLD cycles when others wait: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int unsigned NSLOT = 1 << SEL_W;

  if (N_REQ < 2 || N_REQ > NSLOT || MAX_HOLD < 1 || MAX_HOLD >= (1 << HOLD_W)) begin : g_param_check
    $error("mem_arbiter: illegal parameter combination");
  end

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             mem_en_q, mem_en_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] last_q, last_d;

  // Widen req/done to the full select range so an SEL_W-bit index selects exactly.
  logic [NSLOT-1:0] req_pad;
  logic [NSLOT-1:0] done_pad;
  assign req_pad  = NSLOT'(bus.req);
  assign done_pad = NSLOT'(bus.done);

  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic             timeout;
  logic             release_now;

  always_comb begin
    logic [SEL_W:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx_w     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx_w = {1'b0, last_q} + (SEL_W+1)'(k);
      if (idx_w >= (SEL_W+1)'(N_REQ)) begin
        idx_w = idx_w - (SEL_W+1)'(N_REQ);
      end
      if (!win_found && req_pad[idx_w[SEL_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_w[SEL_W-1:0];
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              others_waiting;

  assign others_waiting = |(req_pad & ~(NSLOT'(1) << last_q));
  assign timeout = (hold_q == HOLD_W'(MAX_HOLD - 1)) && others_waiting;

  always_comb begin
    hold_d = hold_q;
    if (state_q != S_GRANT) begin
      hold_d = '0;
    end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign release_now = !req_pad[last_q] || done_pad[last_q] || timeout;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    mem_en_d = mem_en_q;
    busy_d   = busy_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (win_found) begin
          state_d  = S_GRANT;
          grant_d  = N_REQ'(1) << win_idx;
          sel_d    = win_idx;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          last_d   = win_idx;
        end else begin
          state_d  = S_IDLE;
          grant_d  = '0;
          mem_en_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      S_GRANT: begin
        // The grantee index is last_q; its req/done alone decide release.
        if (release_now) begin
          state_d  = S_GAP;
          grant_d  = '0;
          mem_en_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        mem_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      mem_en_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= SEL_W'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      mem_en_q <= mem_en_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.sel    = sel_q;
  assign bus.mem_en = mem_en_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (N_REQ=2); outputs are checked as the packed
// word {grant, sel, mem_en, busy} one half-cycle after each rising edge.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int unsigned vectors;
  int unsigned miscompares;

  mem_arbiter_if #(.N_REQ(2), .SEL_W(3)) bus ();

  mem_arbiter #(
    .N_REQ   (2),
    .SEL_W   (3),
    .MAX_HOLD(16),
    .HOLD_W  (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [6:0] outs;
  assign outs = {bus.grant, bus.sel, bus.mem_en, bus.busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.done = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req = 2'b11;
    bus.done = 2'b00;
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if (outs !== 7'b00_000_0_0) begin
        miscompares++;
        $display("FAIL reset_c%0d: got %b want %b", c, outs, 7'b00_000_0_0);
      end
    end
  endtask

  task automatic test_single_grant;
    do_reset();
    bus.req = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      step();
      vectors++;
      if (outs !== 7'b01_000_1_1) begin
        miscompares++;
        $display("FAIL single_c%0d: got %b want %b", c, outs, 7'b01_000_1_1);
      end
    end
    bus.req = 2'b00;
    step();
    vectors++;
    if (outs !== 7'b00_000_0_1) begin
      miscompares++;
      $display("FAIL single_release: got %b want %b", outs, 7'b00_000_0_1);
    end
    step();
    vectors++;
    if (outs !== 7'b00_000_0_0) begin
      miscompares++;
      $display("FAIL single_idle: got %b want %b", outs, 7'b00_000_0_0);
    end
  endtask

  task automatic test_done_handoff;
    do_reset();
    bus.req = 2'b11;
    step();
    vectors++;
    if (outs !== 7'b01_000_1_1) begin
      miscompares++;
      $display("FAIL handoff_first: got %b want %b", outs, 7'b01_000_1_1);
    end
    bus.done = 2'b01;
    step();
    bus.done = 2'b00;
    vectors++;
    if (outs !== 7'b00_000_0_1) begin
      miscompares++;
      $display("FAIL handoff_gap: got %b want %b", outs, 7'b00_000_0_1);
    end
    step();
    vectors++;
    if (outs !== 7'b10_001_1_1) begin
      miscompares++;
      $display("FAIL handoff_second: got %b want %b", outs, 7'b10_001_1_1);
    end
    bus.req = 2'b00;
    step();
    vectors++;
    if (outs !== 7'b00_001_0_1) begin
      miscompares++;
      $display("FAIL handoff_sel_gap: got %b want %b", outs, 7'b00_001_0_1);
    end
    step();
    vectors++;
    if (outs !== 7'b00_001_0_0) begin
      miscompares++;
      $display("FAIL handoff_sel_idle: got %b want %b", outs, 7'b00_001_0_0);
    end
  endtask

  task automatic test_ignore_done;
    do_reset();
    bus.done = 2'b11;
    step();
    vectors++;
    if (outs !== 7'b00_000_0_0) begin
      miscompares++;
      $display("FAIL ignore_idle_done: got %b want %b", outs, 7'b00_000_0_0);
    end
    bus.done = 2'b00;
    bus.req = 2'b01;
    step();
    bus.done = 2'b10;
    step();
    bus.done = 2'b00;
    vectors++;
    if (outs !== 7'b01_000_1_1) begin
      miscompares++;
      $display("FAIL ignore_other_done: got %b want %b", outs, 7'b01_000_1_1);
    end
    bus.req = 2'b00;
  endtask

  task automatic test_round_robin;
    logic [1:0] eg;
    logic [2:0] es;
    do_reset();
    bus.req = 2'b11;
    step();
    for (int n = 0; n < 20; n++) begin
      eg = (n % 2 == 0) ? 2'b01 : 2'b10;
      es = (n % 2 == 0) ? 3'd0 : 3'd1;
      vectors++;
      if (outs !== {eg, es, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %b want %b", n, outs, {eg, es, 1'b1, 1'b1});
      end
      step();
      step();
      bus.done = eg;
      step();
      bus.done = 2'b00;
      vectors++;
      if (outs !== {2'b00, es, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL rr_gap%0d: got %b want %b", n, outs, {2'b00, es, 1'b0, 1'b1});
      end
      step();
    end
    bus.req = 2'b00;
  endtask

  task automatic test_hold;
    int unsigned cnt;
    int unsigned exp_cnt;
`ifdef MEM_ARB_TIMEOUT_EN
    exp_cnt = 16;
`else
    exp_cnt = 100;
`endif
    do_reset();
    bus.req = 2'b01;
    step();
    cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 2) bus.req = 2'b11;
      if (bus.grant !== 2'b01) break;
      cnt++;
      if (c < 100) step();
    end
    vectors++;
    if (cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL hold_cycles: got %0d want %0d", cnt, exp_cnt);
    end
    if (cnt == 100) begin
      bus.req = 2'b10;
      step();
    end
    vectors++;
    if (outs !== 7'b00_000_0_1) begin
      miscompares++;
      $display("FAIL hold_gap: got %b want %b", outs, 7'b00_000_0_1);
    end
    step();
    vectors++;
    if (outs !== 7'b10_001_1_1) begin
      miscompares++;
      $display("FAIL hold_next: got %b want %b", outs, 7'b10_001_1_1);
    end
    bus.req = 2'b00;
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    bus.req = 2'b10;
    step();
    vectors++;
    if (outs !== 7'b10_001_1_1) begin
      miscompares++;
      $display("FAIL midrst_pre: got %b want %b", outs, 7'b10_001_1_1);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (outs !== 7'b00_000_0_0) begin
      miscompares++;
      $display("FAIL midrst_drop: got %b want %b", outs, 7'b00_000_0_0);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (outs !== 7'b10_001_1_1) begin
      miscompares++;
      $display("FAIL midrst_regrant: got %b want %b", outs, 7'b10_001_1_1);
    end
    bus.req = 2'b00;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.done = 2'b00;
    @(negedge clk);
    test_reset();
    test_single_grant();
    test_done_handoff();
    test_ignore_done();
    test_round_robin();
    test_hold();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
